serial_magnitude_comparator: RTL and testbench

Multi-cycle N-bit magnitude comparator that consumes two parallel operands and resolves them one bit per clock, MSB first, using the same per-bit greater/less/equal decision as the team's 1-bit comparator. It sits downstream of the operand registers and upstream of any consumer that needs a registered, handshaked comparison result. It returns the three mutually exclusive flags `a_maior_que_b`, `a_menor_que_b` and `a_igual_b`, with a start/busy/done handshake.

---
 rtl/serial_magnitude_comparator.sv | 144 ++++++++++++++
 tb/tb_serial_magnitude_comparator.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator
//
// Multi-cycle unsigned magnitude comparator. Operands are captured on an
// accepted start and resolved one bit per clock, MSB first. The first
// differing bit pair fixes the decision; later bits are ignored.
//
// Ports:
//   clk            - clock, rising edge
//   rst            - asynchronous active-high reset
//   start          - request a comparison (sampled only when idle)
//   a, b           - WIDTH-bit unsigned operands, captured on accepted start
//   busy           - high while a comparison is in progress (shift and done)
//   done           - one-cycle pulse, result flags valid from this cycle on
//   a_maior_que_b  - registered result: a > b
//   a_menor_que_b  - registered result: a < b
//   a_igual_b      - registered result: a == b
//
// Build option:
//   SERIAL_CMP_EARLY_EXIT_EN - when defined, finish on the first differing
//   bit instead of always walking all WIDTH bits. Results are identical.

module serial_magnitude_comparator #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_maior_que_b,
    output logic             a_menor_que_b,
    output logic             a_igual_b
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        DecEq,
        DecGt,
        DecLt
    } decision_e;

    state_e           state_q, state_d;
    decision_e        dec_q, dec_d, dec_new;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;
    logic             bits_differ;
    logic             finish;

    always_comb begin
        state_d     = state_q;
        dec_d       = dec_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        cnt_d       = cnt_q;
        gt_d        = gt_q;
        lt_d        = lt_q;
        eq_d        = eq_q;
        bits_differ = a_sh_q[WIDTH-1] ^ b_sh_q[WIDTH-1];
        dec_new     = dec_q;
        finish      = 1'b0;

        // Only the first differing bit pair may change the decision.
        if (dec_q == DecEq && bits_differ) begin
            dec_new = a_sh_q[WIDTH-1] ? DecGt : DecLt;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    dec_d   = DecEq;
                    cnt_d   = CntW'(WIDTH);
                    state_d = StShift;
                end
            end
            StShift: begin
                dec_d  = dec_new;
                a_sh_d = a_sh_q << 1;
                b_sh_d = b_sh_q << 1;
                cnt_d  = cnt_q - CntW'(1);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
                finish = (cnt_q == CntW'(1)) || (dec_q == DecEq && bits_differ);
`else
                finish = (cnt_q == CntW'(1));
`endif
                if (finish) begin
                    state_d = StDone;
                    gt_d    = (dec_new == DecGt);
                    lt_d    = (dec_new == DecLt);
                    eq_d    = (dec_new == DecEq);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            dec_q   <= DecEq;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone);
    assign a_maior_que_b = gt_q;
    assign a_menor_que_b = lt_q;
    assign a_igual_b     = eq_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench for serial_magnitude_comparator (WIDTH = 8).
// Expected flags and done latency are computed from the operands when a
// comparison is launched, queued, and checked when done is observed.

module tb_serial_magnitude_comparator;

    localparam int unsigned WIDTH = 8;

    typedef struct packed {
        logic [2:0]  flags;  // {gt, lt, eq}
        logic [31:0] lat;    // edge number after which done is expected
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             a_maior_que_b;
    logic             a_menor_que_b;
    logic             a_igual_b;
    bit               clk_en;

    int   n_cmp;
    int   n_err;
    exp_t sb[$];

    serial_magnitude_comparator #(
        .WIDTH(WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .a            (a),
        .b            (b),
        .busy         (busy),
        .done         (done),
        .a_maior_que_b(a_maior_que_b),
        .a_menor_que_b(a_menor_que_b),
        .a_igual_b    (a_igual_b)
    );

    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b);
        exp_t e;
        int   k;
        k = 0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (k == 0 && op_a[i] != op_b[i]) k = WIDTH - i;
        end
        if (op_a > op_b)      e.flags = 3'b100;
        else if (op_a < op_b) e.flags = 3'b010;
        else                  e.flags = 3'b001;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        e.lat = (k != 0) ? 32'(k) : 32'(WIDTH);
`else
        e.lat = 32'(WIDTH);
`endif
        return e;
    endfunction

    function automatic logic [31:0] flags_now();
        return 32'({a_maior_que_b, a_menor_que_b, a_igual_b});
    endfunction

    // Launch one comparison and wait (bounded) for its done pulse. With
    // inject set, new operands and a start pulse are driven mid-operation.
    task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                          input bit inject);
        exp_t e;
        bit   seen;
        @(negedge clk);
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        sb.push_back(model(op_a, op_b));
        @(posedge clk);  // edge 0
        #1 start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n <= int'(WIDTH) + 4 && !seen; n++) begin
            @(negedge clk);  // cycle after edge n
            if (done) begin
                seen = 1'b1;
                e = sb.pop_front();
                check("latency", 32'(n), e.lat);
                check("flags", flags_now(), 32'(e.flags));
                check("busy_at_done", 32'(busy), 32'd1);
            end else if (n == 0) begin
                check("busy_rise", 32'(busy), 32'd1);
            end
            if (inject && n == 2) begin
                a     = '0;
                b     = '1;
                start = 1'b1;
            end
            if (inject && n == 3) start = 1'b0;
        end
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
            if (sb.size() != 0) void'(sb.pop_front());
        end else begin
            @(negedge clk);
            check("post_done_busy", 32'(busy), 32'd0);
            check("post_done_single", 32'(done), 32'd0);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        clk_en = 1'b0;
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;

        // Reset with no clock running.
        #3;
        check("reset_flags", flags_now(), 32'h1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);

        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(8'hA5, 8'hA5, 1'b0);
        run_op(8'h80, 8'h7F, 1'b0);
        run_op(8'h12, 8'h13, 1'b0);

        // Flags hold between operations.
        repeat (3) @(negedge clk);
        check("hold_flags", flags_now(), 32'h2);

        run_op(8'h05, 8'h03, 1'b1);

        // Reset asserted just after edge 4 of an in-flight compare.
        @(negedge clk);
        a     = 8'hF0;
        b     = 8'h0F;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_flags", flags_now(), 32'h1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_done", 32'(done), 32'd0);
        end
        rst = 1'b0;

        run_op(8'h01, 8'h02, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b0);
        run_op(8'h00, 8'h01, 1'b0);
        run_op(8'hFF, 8'hFE, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_op(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)), 1'b0);
        end

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
